// File: rtl/rvfi_step_sched_pkg.sv
// ---------------------------------------------------------------------------
// rvfi_step_sched_pkg
// Shared types for the RVFI step scheduler:
//   retire_entry_t : one buffered retirement {order, pc, intr, mip}
//   sched_state_e  : handshake FSM states (IDLE / INTR / STEP)
//   step_count_inc : wrapping increment of the completed-step counter
// The pc field is sized for the widest supported XLEN (64); narrower cores
// zero-extend into it and truncate on the way out.
// ---------------------------------------------------------------------------
package rvfi_step_sched_pkg;

  localparam int unsigned ORDER_W  = 64;
  localparam int unsigned PC_MAX_W = 64;
  localparam int unsigned MIP_W    = 32;
  localparam int unsigned STEPS_W  = 32;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [PC_MAX_W-1:0] pc;
    logic                intr;
    logic [MIP_W-1:0]    mip;
  } retire_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INTR = 2'd1,
    ST_STEP = 2'd2
  } sched_state_e;

  // Completed-step counter wraps 0xFFFFFFFF -> 0 rather than saturating.
  function automatic logic [STEPS_W-1:0] step_count_inc(input logic [STEPS_W-1:0] cnt);
    return cnt + STEPS_W'(1);
  endfunction

endpackage

// File: rtl/rvfi_step_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// rvfi_step_fifo
// Retirement buffer for the step scheduler. DEPTH entries, power of two, so
// the read/write pointers wrap naturally modulo DEPTH.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle (the freed slot is the one being written). Pops on an empty
// buffer are ignored.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers/fill)
//   push, wr_data    write request and entry
//   pop              remove head entry
//   accept           push was taken this cycle
//   head             entry at the read pointer (valid only when !empty)
//   full, empty      occupancy flags
//   fill             number of buffered entries, 0..DEPTH
// ---------------------------------------------------------------------------
module rvfi_step_fifo
  import rvfi_step_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  retire_entry_t                wr_data,
  input  logic                         pop,
  output logic                         accept,
  output retire_entry_t                head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH+1);

  retire_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [FILL_W-1:0]  fill_q;
  logic               pop_ok;

  assign full   = (fill_q == FILL_W'(DEPTH));
  assign empty  = (fill_q == '0);
  assign pop_ok = pop && !empty;
  assign accept = push && (!full || pop_ok);
  assign head   = mem[rd_ptr_q];
  assign fill   = fill_q;

  // Storage carries no reset: an entry is only observed once fill covers it.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({accept, pop_ok})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_step_scheduler.sv
// ---------------------------------------------------------------------------
// rvfi_step_scheduler
// Buffers RVFI retirements and replays them to a reference model one step at
// a time. An entry flagged as the first instruction of a trap handler first
// presents its mip value (intr_req_o/intr_ack_i handshake) and then requests
// the model step (step_req_o/step_ack_i). Each completed step pops the buffer.
//
// Optional feature macro: RVFI_STEP_SCHED_ORDER_CHECK_EN
//   defined   -> order_err_o goes sticky when an accepted retirement's order
//                is not the previously accepted order + 1 (first one exempt)
//   undefined -> order_err_o tied to 0
//
// Parameters: DEPTH (buffer entries, power of two, >=2), XLEN (PC width, <=64)
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   rvfi_valid_i/order/pc/intr   retirement from the core
//   mip_i                        interrupt-pending value at retirement
//   intr_req_o, intr_irq_o       request model to apply mip; mip value
//   intr_ack_i                   model applied mip
//   step_req_o, step_pc_o,
//   step_order_o                 request one model step for the head entry
//   step_ack_i                   model step complete
//   fill_o                       buffered entries
//   steps_o                      completed steps (wrapping)
//   overflow_o                   sticky: a retirement was dropped (buffer full)
//   order_err_o                  sticky: order discontinuity (see macro)
// ---------------------------------------------------------------------------
module rvfi_step_scheduler
  import rvfi_step_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rvfi_valid_i,
  input  logic [63:0]                  rvfi_order_i,
  input  logic [XLEN-1:0]              rvfi_pc_i,
  input  logic                         rvfi_intr_i,
  input  logic [31:0]                  mip_i,
  output logic                         intr_req_o,
  output logic [31:0]                  intr_irq_o,
  input  logic                         intr_ack_i,
  output logic                         step_req_o,
  output logic [XLEN-1:0]              step_pc_o,
  output logic [63:0]                  step_order_o,
  input  logic                         step_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o,
  output logic [31:0]                  steps_o,
  output logic                         overflow_o,
  output logic                         order_err_o
);

  retire_entry_t  wr_entry;
  retire_entry_t  head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_accept;
  logic           pop;

  sched_state_e   state_q;
  sched_state_e   state_d;
  logic [31:0]    steps_q;
  logic           overflow_q;

  // Retirement capture: widen pc into the package-wide entry layout.
  always_comb begin
    wr_entry             = '0;
    wr_entry.order       = rvfi_order_i;
    wr_entry.pc[XLEN-1:0] = rvfi_pc_i;
    wr_entry.intr        = rvfi_intr_i;
    wr_entry.mip         = mip_i;
  end

  rvfi_step_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .push    (rvfi_valid_i),
    .wr_data (wr_entry),
    .pop     (pop),
    .accept  (fifo_accept),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill_o)
  );

  // Handshake FSM: next state and pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = head.intr ? ST_INTR : ST_STEP;
        end
      end
      ST_INTR: begin
        if (intr_ack_i) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (step_ack_i) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded purely from state and the buffer head, so they stay
  // stable for the whole handshake and read as zero whenever idle.
  always_comb begin
    intr_req_o   = 1'b0;
    intr_irq_o   = '0;
    step_req_o   = 1'b0;
    step_pc_o    = '0;
    step_order_o = '0;
    case (state_q)
      ST_INTR: begin
        intr_req_o = 1'b1;
        intr_irq_o = head.mip;
      end
      ST_STEP: begin
        step_req_o   = 1'b1;
        step_pc_o    = head.pc[XLEN-1:0];
        step_order_o = head.order;
      end
      default: ;
    endcase
  end

  // Upper pc bits exist only to share one entry layout across XLEN values.
  logic unused_head_pc;
  assign unused_head_pc = ^head.pc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      steps_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        steps_q <= step_count_inc(steps_q);
      end
      // Dropped: full buffer and no pop freeing a slot this cycle.
      if (rvfi_valid_i && !fifo_accept) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign steps_o    = steps_q;
  assign overflow_o = overflow_q;

`ifdef RVFI_STEP_SCHED_ORDER_CHECK_EN
  logic        have_prev_q;
  logic [63:0] prev_order_q;
  logic        order_err_q;

  // Only accepted retirements take part; dropped ones are never compared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      have_prev_q  <= 1'b0;
      prev_order_q <= '0;
      order_err_q  <= 1'b0;
    end else if (fifo_accept) begin
      if (have_prev_q && (rvfi_order_i != prev_order_q + 64'd1)) begin
        order_err_q <= 1'b1;
      end
      prev_order_q <= rvfi_order_i;
      have_prev_q  <= 1'b1;
    end
  end

  assign order_err_o = order_err_q;
`else
  assign order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_step_scheduler.sv
module tb_rvfi_step_scheduler;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int FW    = $clog2(DEPTH+1);

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              rvfi_valid_i;
  logic [63:0]       rvfi_order_i;
  logic [XLEN-1:0]   rvfi_pc_i;
  logic              rvfi_intr_i;
  logic [31:0]       mip_i;
  logic              intr_req_o;
  logic [31:0]       intr_irq_o;
  logic              intr_ack_i;
  logic              step_req_o;
  logic [XLEN-1:0]   step_pc_o;
  logic [63:0]       step_order_o;
  logic              step_ack_i;
  logic [FW-1:0]     fill_o;
  logic [31:0]       steps_o;
  logic              overflow_o;
  logic              order_err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic            intr;
    logic [31:0]     mip;
  } ent_t;

  ent_t q[$];

  always #5 clk_i = ~clk_i;

  rvfi_step_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rvfi_valid_i (rvfi_valid_i),
    .rvfi_order_i (rvfi_order_i),
    .rvfi_pc_i    (rvfi_pc_i),
    .rvfi_intr_i  (rvfi_intr_i),
    .mip_i        (mip_i),
    .intr_req_o   (intr_req_o),
    .intr_irq_o   (intr_irq_o),
    .intr_ack_i   (intr_ack_i),
    .step_req_o   (step_req_o),
    .step_pc_o    (step_pc_o),
    .step_order_o (step_order_o),
    .step_ack_i   (step_ack_i),
    .fill_o       (fill_o),
    .steps_o      (steps_o),
    .overflow_o   (overflow_o),
    .order_err_o  (order_err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rvfi_valid_i = 1'b0;
    rvfi_order_i = '0;
    rvfi_pc_i    = '0;
    rvfi_intr_i  = 1'b0;
    mip_i        = '0;
    intr_ack_i   = 1'b0;
    step_ack_i   = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic retire(input logic [63:0] order, input logic [XLEN-1:0] pc,
                        input logic intr, input logic [31:0] mip);
    rvfi_valid_i = 1'b1;
    rvfi_order_i = order;
    rvfi_pc_i    = pc;
    rvfi_intr_i  = intr;
    mip_i        = mip;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    checks++;
    if ({intr_req_o, step_req_o, overflow_o, order_err_o} !== 4'b0 || fill_o !== '0 ||
        steps_o !== 32'd0 || intr_irq_o !== 32'd0 || step_pc_o !== '0 || step_order_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b/%b fill=%0d steps=%0d ovf=%b oerr=%b want all zero",
               intr_req_o, step_req_o, fill_o, steps_o, overflow_o, order_err_o);
    end
    rst_ni = 1'b1;
    tick();
    checks++;
    if (step_req_o !== 1'b0 || intr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got req=%b/%b want 0/0", intr_req_o, step_req_o);
    end
  endtask

  task automatic test_single_step();
    apply_reset();
    retire(64'd5, 32'h80, 1'b0, 32'h0);
    tick();
    rvfi_valid_i = 1'b0;
    checks++;
    if (fill_o !== FW'(1) || step_req_o !== 1'b0) begin
      errors++;
      $display("FAIL single_push got fill=%0d req=%b want fill=1 req=0", fill_o, step_req_o);
    end
    tick();
    checks++;
    if (step_req_o !== 1'b1 || step_pc_o !== 32'h80 || step_order_o !== 64'd5 || intr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL single_req got req=%b pc=%h order=%0d want req=1 pc=80 order=5",
               step_req_o, step_pc_o, step_order_o);
    end
    step_ack_i = 1'b1;
    tick();
    step_ack_i = 1'b0;
    checks++;
    if (steps_o !== 32'd1 || fill_o !== FW'(0) || step_req_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done got steps=%0d fill=%0d req=%b want steps=1 fill=0 req=0",
               steps_o, fill_o, step_req_o);
    end
  endtask

  task automatic test_intr();
    apply_reset();
    retire(64'd9, 32'h84, 1'b1, 32'h800);
    tick();
    rvfi_valid_i = 1'b0;
    tick();
    checks++;
    if (intr_req_o !== 1'b1 || intr_irq_o !== 32'h800 || step_req_o !== 1'b0) begin
      errors++;
      $display("FAIL intr_req got ireq=%b irq=%h sreq=%b want 1 800 0", intr_req_o, intr_irq_o, step_req_o);
    end
    step_ack_i = 1'b1;  // stray step ack in INTR must be ignored
    tick();
    step_ack_i = 1'b0;
    checks++;
    if (intr_req_o !== 1'b1 || intr_irq_o !== 32'h800 || step_req_o !== 1'b0 || steps_o !== 32'd0) begin
      errors++;
      $display("FAIL intr_hold got ireq=%b irq=%h sreq=%b steps=%0d want 1 800 0 0",
               intr_req_o, intr_irq_o, step_req_o, steps_o);
    end
    intr_ack_i = 1'b1;
    tick();
    intr_ack_i = 1'b0;
    checks++;
    if (step_req_o !== 1'b1 || intr_req_o !== 1'b0 || step_pc_o !== 32'h84 || step_order_o !== 64'd9) begin
      errors++;
      $display("FAIL intr_then_step got sreq=%b ireq=%b pc=%h want 1 0 84", step_req_o, intr_req_o, step_pc_o);
    end
    step_ack_i = 1'b1;
    tick();
    step_ack_i = 1'b0;
    checks++;
    if (steps_o !== 32'd1 || fill_o !== FW'(0)) begin
      errors++;
      $display("FAIL intr_done got steps=%0d fill=%0d want 1 0", steps_o, fill_o);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] exp_order;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      retire(64'(i), 32'(32'h100 + 4 * i), 1'b0, 32'h0);
      tick();
      if (i == 4) begin
        checks++;
        if (fill_o !== FW'(4) || overflow_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full got fill=%0d ovf=%b want 4 0", fill_o, overflow_o);
        end
      end
    end
    rvfi_valid_i = 1'b0;
    checks++;
    if (fill_o !== FW'(4) || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop got fill=%0d ovf=%b want 4 1", fill_o, overflow_o);
    end
    step_ack_i = 1'b1;
    exp_order = 64'd1;
    for (int c = 0; c < 20 && exp_order <= 64'd4; c++) begin
      if (step_req_o === 1'b1) begin
        checks++;
        if (step_order_o !== exp_order) begin
          errors++;
          $display("FAIL ovf_drain_order got %0d want %0d", step_order_o, exp_order);
        end
        exp_order++;
      end
      tick();
    end
    step_ack_i = 1'b0;
    tick();
    checks++;
    if (exp_order !== 64'd5 || steps_o !== 32'd4 || fill_o !== FW'(0) || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain got seen=%0d steps=%0d fill=%0d ovf=%b want 4 4 0 1",
               exp_order - 1, steps_o, fill_o, overflow_o);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      retire(64'(i), 32'(32'h200 + 4 * i), 1'b0, 32'h0);
      tick();
    end
    retire(64'd5, 32'h214, 1'b0, 32'h0);
    step_ack_i = 1'b1;
    tick();
    rvfi_valid_i = 1'b0;
    step_ack_i   = 1'b0;
    checks++;
    if (fill_o !== FW'(4) || overflow_o !== 1'b0 || steps_o !== 32'd1) begin
      errors++;
      $display("FAIL full_pop got fill=%0d ovf=%b steps=%0d want 4 0 1", fill_o, overflow_o, steps_o);
    end
    tick();
    checks++;
    if (step_req_o !== 1'b1 || step_order_o !== 64'd2) begin
      errors++;
      $display("FAIL full_pop_next got req=%b order=%0d want 1 2", step_req_o, step_order_o);
    end
  endtask

  task automatic test_order_check();
    logic exp_err;
`ifdef RVFI_STEP_SCHED_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    apply_reset();
    retire(64'd1, 32'h10, 1'b0, 32'h0);
    tick();
    retire(64'd2, 32'h14, 1'b0, 32'h0);
    tick();
    checks++;
    if (order_err_o !== 1'b0) begin
      errors++;
      $display("FAIL order_ok got %b want 0", order_err_o);
    end
    retire(64'd4, 32'h18, 1'b0, 32'h0);
    tick();
    rvfi_valid_i = 1'b0;
    checks++;
    if (order_err_o !== exp_err) begin
      errors++;
      $display("FAIL order_gap got %b want %b", order_err_o, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      retire(64'(i), 32'(32'h300 + 4 * i), 1'b0, 32'h0);
      tick();
    end
    rvfi_valid_i = 1'b0;
    checks++;
    if (step_req_o !== 1'b1 || fill_o !== FW'(3)) begin
      errors++;
      $display("FAIL mid_setup got req=%b fill=%0d want 1 3", step_req_o, fill_o);
    end
    step_ack_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (step_req_o !== 1'b0 || fill_o !== '0 || steps_o !== 32'd0 || step_pc_o !== '0 ||
        step_order_o !== 64'd0 || intr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got req=%b fill=%0d steps=%0d pc=%h want all zero",
               step_req_o, fill_o, steps_o, step_pc_o);
    end
    step_ack_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (step_req_o !== 1'b0 || intr_req_o !== 1'b0 || fill_o !== '0 || steps_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_after got req=%b/%b fill=%0d steps=%0d want 0 0 0 0",
               intr_req_o, step_req_o, fill_o, steps_o);
    end
  endtask

  task automatic test_random();
    int          idle_run;
    bit          intr_done;
    bit          m_ovf;
    int unsigned m_steps;
    logic [63:0] last_order;
    bit          pop;
    bit          push_ok;
    ent_t        e;
    apply_reset();
    q.delete();
    idle_run   = 0;
    intr_done  = 0;
    m_ovf      = 0;
    m_steps    = 0;
    last_order = 64'd1000;
    for (int cyc = 0; cyc < 700; cyc++) begin
      checks++;
      if (fill_o !== FW'(q.size()) || steps_o !== 32'(m_steps) || overflow_o !== m_ovf) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got fill=%0d steps=%0d ovf=%b want %0d %0d %b",
                 cyc, fill_o, steps_o, overflow_o, q.size(), m_steps, m_ovf);
      end
      checks++;
      if (intr_req_o === 1'b1 && step_req_o === 1'b1) begin
        errors++;
        $display("FAIL rand_excl cyc=%0d got both requests high want at most one", cyc);
      end
      if (step_req_o === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_step_empty cyc=%0d got step_req=1 want 0 with empty model", cyc);
        end else if (step_pc_o !== q[0].pc || step_order_o !== q[0].order || (q[0].intr && !intr_done)) begin
          errors++;
          $display("FAIL rand_step cyc=%0d got pc=%h order=%0d want pc=%h order=%0d intr_first=%b",
                   cyc, step_pc_o, step_order_o, q[0].pc, q[0].order, q[0].intr && !intr_done);
        end
      end
      if (intr_req_o === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_intr_empty cyc=%0d got intr_req=1 want 0 with empty model", cyc);
        end else if (!q[0].intr || intr_done || intr_irq_o !== q[0].mip) begin
          errors++;
          $display("FAIL rand_intr cyc=%0d got irq=%h want irq=%h intr=%b", cyc, intr_irq_o, q[0].mip, q[0].intr);
        end
      end
      if (q.size() > 0 && intr_req_o !== 1'b1 && step_req_o !== 1'b1) idle_run++;
      else idle_run = 0;
      checks++;
      if (idle_run > 1) begin
        errors++;
        $display("FAIL rand_latency cyc=%0d got %0d idle cycles with data want <=1", cyc, idle_run);
      end
      order_err_check: begin
        checks++;
        if (order_err_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_order_err cyc=%0d got 1 want 0", cyc);
        end
      end

      e.order = last_order + 64'd1;
      e.pc    = $urandom & 32'hFFFF_FFFC;
      e.intr  = ($urandom_range(0, 3) == 0);
      e.mip   = $urandom;
      rvfi_valid_i = ($urandom_range(0, 99) < 45);
      rvfi_order_i = e.order;
      rvfi_pc_i    = e.pc;
      rvfi_intr_i  = e.intr;
      mip_i        = e.mip;
      step_ack_i   = ($urandom_range(0, 99) < ((cyc < 350) ? 55 : 15));
      intr_ack_i   = ($urandom_range(0, 99) < 50);

      pop     = (step_req_o === 1'b1) && step_ack_i;
      push_ok = rvfi_valid_i && (q.size() < DEPTH || pop);
      if (intr_req_o === 1'b1 && intr_ack_i) intr_done = 1;
      if (pop) begin
        void'(q.pop_front());
        intr_done = 0;
        m_steps++;
      end
      if (push_ok) begin
        q.push_back(e);
        last_order = e.order;
      end else if (rvfi_valid_i) begin
        m_ovf = 1;
      end
      tick();
    end

    rvfi_valid_i = 1'b0;
    step_ack_i   = 1'b1;
    intr_ack_i   = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (step_req_o === 1'b1) begin
        void'(q.pop_front());
        m_steps++;
      end
      tick();
    end
    step_ack_i = 1'b0;
    intr_ack_i = 1'b0;
    checks++;
    if (q.size() != 0 || fill_o !== FW'(0) || steps_o !== 32'(m_steps)) begin
      errors++;
      $display("FAIL rand_drain got fill=%0d steps=%0d left=%0d want 0 %0d 0",
               fill_o, steps_o, q.size(), m_steps);
    end
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_single_step();
    test_intr();
    test_overflow();
    test_full_pop();
    test_order_check();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_step_scheduler.md
RVFI_STEP_SCHEDULER -- requirements
Module: rvfi_step_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, retirement buffer entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rvfi_valid_i  input  1  core retired one instruction this cycle.
REQ-006 SHALL have port rvfi_order_i  input  64  retirement order number.
REQ-007 SHALL have port rvfi_pc_i  input  XLEN  retired PC.
REQ-008 SHALL have port rvfi_intr_i  input  1  retired instruction is first of a trap handler.
REQ-009 SHALL have port mip_i  input  32  interrupt-pending value at retirement.
REQ-010 SHALL have port intr_req_o  output  1  request model to apply mip; intr_irq_o  output  32  mip value.
REQ-011 SHALL have port intr_ack_i  input  1  model applied mip.
REQ-012 SHALL have port step_req_o  output  1  request one model step; step_pc_o  output  XLEN; step_order_o  output  64.
REQ-013 SHALL have port step_ack_i  input  1  model step complete.
REQ-014 SHALL have port fill_o  output  $clog2(DEPTH+1)  buffered entries.
REQ-015 SHALL have port steps_o  output  32  completed-step count; overflow_o  output  1  sticky; order_err_o  output  1  sticky.

Function
REQ-016 SHALL capture {order, pc, intr, mip} into FIFO on each rising edge with rvfi_valid_i=1 and FIFO not full, or full with a pop in the same cycle.
REQ-017 SHALL drop the entry and set overflow_o when rvfi_valid_i=1, FIFO full, no pop that cycle; fill unchanged.
REQ-018 SHALL run FSM IDLE, INTR, STEP; state registered, outputs decoded from state and FIFO head.
REQ-019 IDLE: FIFO non-empty and head.intr=1 -> INTR; non-empty and head.intr=0 -> STEP; empty -> stay.
REQ-020 INTR: intr_req_o=1, intr_irq_o=head.mip, held stable until intr_ack_i=1 sampled; then -> STEP.
REQ-021 STEP: step_req_o=1, step_pc_o/step_order_o=head fields, held stable until step_ack_i=1 sampled; then pop head, steps_o+1 (wraps 0xFFFFFFFF->0), -> IDLE.
REQ-022 SHALL assert step_req_o (or intr_req_o) in the cycle after the edge following the push into an empty idle FIFO (one-cycle latency).
REQ-023 SHALL ignore intr_ack_i/step_ack_i outside INTR/STEP respectively; ack in same cycle as request rising is valid.
REQ-024 intr_req_o and step_req_o SHALL never be high together; at most one pop per cycle; throughput one step per two cycles.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; fill_o ranges 0..DEPTH.

Reset
REQ-026 rst_ni low SHALL immediately clear FIFO, fill_o=0, state IDLE, all *_req_o=0, intr_irq_o/step_pc_o/step_order_o=0, steps_o=0, overflow_o=0, order_err_o=0.
REQ-027 Reset mid-handshake SHALL abandon the pending request; no pop, no count.

Configuration
REQ-028 With RVFI_STEP_SCHED_ORDER_CHECK_EN defined, SHALL set order_err_o when a captured rvfi_order_i != previously captured order+1; first capture after reset exempt; dropped entries not compared.
REQ-029 Without RVFI_STEP_SCHED_ORDER_CHECK_EN, order_err_o SHALL be tied 0; port remains.

Structure
REQ-030 Package rvfi_step_sched_pkg SHALL hold the entry struct typedef and FSM state enum.
REQ-031 FIFO SHALL be sub-module rvfi_step_fifo (push/pop/full/empty/fill/head).

Verification
REQ-032 Single retire order=5, pc=0x80, intr=0, step_ack one cycle after req -> step_req_o high 1 cycle after push, step_pc_o=0x80, steps_o=1, fill_o back to 0.
REQ-033 Retire intr=1, mip=0x800 -> intr_req_o with intr_irq_o=0x800 first, then step_req_o only after intr_ack_i; steps_o=1.
REQ-034 DEPTH=4, step_ack_i held 0, 5 consecutive retires -> fill_o=4, overflow_o=1, 5th dropped; releasing ack drains 4 steps, steps_o=4.
REQ-035 Full FIFO, retire coincident with step ack -> entry accepted, fill_o stays 4, overflow_o stays 0.
REQ-036 With macro, orders 1,2,4 -> order_err_o=1 after third capture; without macro -> stays 0.
REQ-037 rst_ni low while step_req_o=1 with 3 entries -> all outputs 0 asynchronously; after release no request until new retire.
